// File: rtl/core_pkg.sv
// Shared definitions for the Eka core: datapath widths, ALU opcodes and
// operand select encodings used by decode and execute.
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] SRC1_RS1  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;

  localparam logic [1:0] SRC2_RS2  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b10;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand forwarder: MEM result beats WB result beats the register
// value; x0 is never forwarded. Tie mem_valid low to get a WB-only forwarder.
module fwd_mux #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] regval,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  logic addr_nz;
  logic mem_hit;
  logic wb_hit;

  assign addr_nz = (addr != '0);
  // A load in MEM has no data yet; the load-use bubble covers that case.
  assign mem_hit = mem_valid & mem_reg_write & ~mem_is_load & (mem_rd == addr) & addr_nz;
  assign wb_hit  = wb_valid & wb_reg_write & (wb_rd == addr) & addr_nz;

  always_comb begin
    data = regval;
    if (mem_hit) begin
      data = mem_result;
    end else if (wb_hit) begin
      data = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, load-use
// bubble insertion, flush and downstream hold.
module ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic [1:0]      id_src1_sel,
  input  logic [1:0]      id_src2_sel,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            id_is_store,
  input  logic            ex_hold,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [3:0]      alu_opcode,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            ex_is_store
);

  logic            ex_valid_q,     ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,        ex_pc_d;
  logic [XLEN-1:0] ex_imm_q,       ex_imm_d;
  logic [XLEN-1:0] ex_rs1_data_q,  ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q,  ex_rs2_data_d;
  logic [RA_W-1:0] ex_rs1_q,       ex_rs1_d;
  logic [RA_W-1:0] ex_rs2_q,       ex_rs2_d;
  logic [RA_W-1:0] ex_rd_q,        ex_rd_d;
  logic [3:0]      ex_alu_op_q,    ex_alu_op_d;
  logic [1:0]      ex_src1_sel_q,  ex_src1_sel_d;
  logic [1:0]      ex_src2_sel_q,  ex_src2_sel_d;
  logic            ex_reg_write_q, ex_reg_write_d;
  logic            ex_is_load_q,   ex_is_load_d;
  logic            ex_is_store_q,  ex_is_store_d;

  logic [XLEN-1:0] id_r1, id_r2, r1, r2;
  logic            lu;

  // Capture-side forwarders see only WB; MEM is picked up once in EX.
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_id_rs1 (
    .addr(id_rs1), .regval(id_rs1_data),
    .mem_valid(1'b0), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .data(id_r1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_id_rs2 (
    .addr(id_rs2), .regval(id_rs2_data),
    .mem_valid(1'b0), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .data(id_r2)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_ex_rs1 (
    .addr(ex_rs1_q), .regval(ex_rs1_data_q),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .data(r1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_ex_rs2 (
    .addr(ex_rs2_q), .regval(ex_rs2_data_q),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .data(r2)
  );

  assign lu = ex_valid_q & ex_is_load_q & (ex_rd_q != '0) & id_valid &
              ((id_rs1 == ex_rd_q) | (id_rs2 == ex_rd_q));
  assign id_ready = ~ex_hold & ~lu & ~flush;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_imm_d       = ex_imm_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_alu_op_d    = ex_alu_op_q;
    ex_src1_sel_d  = ex_src1_sel_q;
    ex_src2_sel_d  = ex_src2_sel_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_is_load_d   = ex_is_load_q;
    ex_is_store_d  = ex_is_store_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_hold) begin
      // Refresh operands so a WB producer retiring mid-hold is not lost.
      ex_rs1_data_d = r1;
      ex_rs2_data_d = r2;
    end else if (lu) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      ex_pc_d        = id_pc;
      ex_imm_d       = id_imm;
      ex_rs1_data_d  = id_r1;
      ex_rs2_data_d  = id_r2;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_rd_d        = id_rd;
      ex_alu_op_d    = id_alu_op;
      ex_src1_sel_d  = id_src1_sel;
      ex_src2_sel_d  = id_src2_sel;
      ex_reg_write_d = id_reg_write;
      ex_is_load_d   = id_is_load;
      ex_is_store_d  = id_is_store;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_alu_op_q    <= '0;
      ex_src1_sel_q  <= '0;
      ex_src2_sel_q  <= '0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_is_store_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_src1_sel_q  <= ex_src1_sel_d;
      ex_src2_sel_q  <= ex_src2_sel_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_is_store_q  <= ex_is_store_d;
    end
  end

  always_comb begin
    case (ex_src1_sel_q)
      SRC1_RS1:  alu_src1 = r1;
      SRC1_PC:   alu_src1 = ex_pc_q;
      SRC1_ZERO: alu_src1 = '0;
      default:   alu_src1 = '0;
    endcase
    case (ex_src2_sel_q)
      SRC2_RS2:  alu_src2 = r2;
      SRC2_IMM:  alu_src2 = ex_imm_q;
      SRC2_FOUR: alu_src2 = XLEN'(4);
      default:   alu_src2 = '0;
    endcase
  end

  assign alu_opcode    = ex_alu_op_q;
  assign ex_store_data = r2;
  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_pc_q;
  assign ex_imm        = ex_imm_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_valid_q & ex_reg_write_q;
  assign ex_is_load    = ex_valid_q & ex_is_load_q;
  assign ex_is_store   = ex_valid_q & ex_is_store_q;

  // The load-use bubble must keep a load in MEM from ever feeding EX.
  a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (reset)
    !(ex_valid_q & mem_valid & mem_is_load & (mem_rd != '0) &
      ((mem_rd == ex_rs1_q) | (mem_rd == ex_rs2_q))));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, load-use bubble, hold
// refresh, flush, link operands and asynchronous reset.
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]      id_alu_op;
  logic [1:0]      id_src1_sel, id_src2_sel;
  logic            id_reg_write, id_is_load, id_is_store;
  logic            ex_hold, flush;
  logic            mem_valid, mem_reg_write, mem_is_load;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_valid, wb_reg_write;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] alu_src1, alu_src2, ex_store_data, ex_pc, ex_imm;
  logic [3:0]      alu_opcode;
  logic            ex_valid, ex_reg_write, ex_is_load, ex_is_store;
  logic [RA_W-1:0] ex_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .ex_hold(ex_hold), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_opcode(alu_opcode),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                        input logic [RA_W-1:0] rs1, input logic [XLEN-1:0] rs1d,
                        input logic [RA_W-1:0] rs2, input logic [XLEN-1:0] rs2d,
                        input logic [XLEN-1:0] imm, input logic [RA_W-1:0] rd,
                        input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                        input logic rw, input logic ld, input logic st);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = rs1d;
    id_rs2 = rs2; id_rs2_data = rs2d; id_imm = imm; id_rd = rd;
    id_alu_op = op; id_src1_sel = s1; id_src2_sel = s2;
    id_reg_write = rw; id_is_load = ld; id_is_store = st;
  endtask

  task automatic idle_mem_wb();
    mem_valid = 0; mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic test_reset();
    reset = 1; ex_hold = 0; flush = 0;
    idle_mem_wb();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    n_cmp++; if (alu_src1 !== 32'h0) begin n_bad++; $display("FAIL reset_alu_src1 got %h want 0", alu_src1); end
    n_cmp++; if (alu_opcode !== 4'h0) begin n_bad++; $display("FAIL reset_alu_opcode got %h want 0", alu_opcode); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_id_ready got %0b want 1", id_ready); end
    reset = 0;
    tick();
  endtask

  task automatic test_alu_forward();
    // addi x1,x0,5
    set_id(1, 32'h0, 0, 0, 0, 0, 32'd5, 1, 4'b0000, 2'b00, 2'b01, 1, 0, 0);
    tick();
    n_cmp++; if (alu_src2 !== 32'd5) begin n_bad++; $display("FAIL addi_src2 got %h want 5", alu_src2); end
    n_cmp++; if (ex_reg_write !== 1'b1) begin n_bad++; $display("FAIL addi_reg_write got %0b want 1", ex_reg_write); end
    // add x2,x1,x1 with stale regfile data
    set_id(1, 32'h4, 1, 0, 1, 0, 0, 2, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    tick();
    mem_valid = 1; mem_reg_write = 1; mem_is_load = 0; mem_rd = 1; mem_result = 32'd5;
    #1;
    n_cmp++; if (alu_src1 !== 32'd5) begin n_bad++; $display("FAIL fwd_mem_src1 got %h want 5", alu_src1); end
    n_cmp++; if (alu_src2 !== 32'd5) begin n_bad++; $display("FAIL fwd_mem_src2 got %h want 5", alu_src2); end
    n_cmp++; if (alu_opcode !== 4'b0000) begin n_bad++; $display("FAIL fwd_opcode got %h want 0", alu_opcode); end
    wb_valid = 1; wb_reg_write = 1; wb_rd = 1; wb_result = 32'd9;
    #1;
    n_cmp++; if (alu_src1 !== 32'd5) begin n_bad++; $display("FAIL fwd_mem_over_wb got %h want 5", alu_src1); end
    mem_valid = 0;
    #1;
    n_cmp++; if (ex_store_data !== 32'd9) begin n_bad++; $display("FAIL fwd_wb_store got %h want 9", ex_store_data); end
    idle_mem_wb();
    id_valid = 0;
    tick();
  endtask

  task automatic test_load_use();
    // lw x3, 0x10(x0)
    set_id(1, 32'h8, 0, 0, 0, 0, 32'h10, 3, 4'b0000, 2'b00, 2'b01, 1, 1, 0);
    tick();
    // add x4,x3,x0
    set_id(1, 32'hC, 3, 0, 0, 0, 0, 4, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    #1;
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_id_ready got %0b want 0", id_ready); end
    n_cmp++; if (ex_is_load !== 1'b1) begin n_bad++; $display("FAIL lu_ex_is_load got %0b want 1", ex_is_load); end
    tick();
    mem_valid = 1; mem_reg_write = 1; mem_is_load = 1; mem_rd = 3; mem_result = 32'h10;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_valid got %0b want 0", ex_valid); end
    n_cmp++; if (ex_is_load !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_is_load got %0b want 0", ex_is_load); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL lu_bubble_ready got %0b want 1", id_ready); end
    tick();
    idle_mem_wb();
    id_valid = 0;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 3; wb_result = 32'hDEADBEEF;
    #1;
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_consumer_valid got %0b want 1", ex_valid); end
    n_cmp++; if (alu_src1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lu_wb_src1 got %h want deadbeef", alu_src1); end
    idle_mem_wb();
    tick();
  endtask

  task automatic test_hold_refresh();
    // sub x6,x1,x5 with stale x5
    set_id(1, 32'h20, 1, 32'h10, 5, 0, 0, 6, 4'b1000, 2'b00, 2'b00, 1, 0, 0);
    tick();
    set_id(1, 32'h24, 2, 32'h1, 2, 32'h1, 0, 9, 4'b0111, 2'b00, 2'b00, 1, 0, 0);
    ex_hold = 1;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5; wb_result = 32'h77;
    #1;
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL hold_id_ready got %0b want 0", id_ready); end
    n_cmp++; if (alu_src2 !== 32'h77) begin n_bad++; $display("FAIL hold_wb_src2 got %h want 77", alu_src2); end
    tick();
    idle_mem_wb();
    #1;
    n_cmp++; if (alu_src2 !== 32'h77) begin n_bad++; $display("FAIL hold_refresh_src2 got %h want 77", alu_src2); end
    n_cmp++; if (alu_src1 !== 32'h10) begin n_bad++; $display("FAIL hold_src1 got %h want 10", alu_src1); end
    tick();
    ex_hold = 0;
    #1;
    n_cmp++; if (alu_src2 !== 32'h77) begin n_bad++; $display("FAIL release_src2 got %h want 77", alu_src2); end
    n_cmp++; if (alu_opcode !== 4'b1000) begin n_bad++; $display("FAIL release_opcode got %h want 8", alu_opcode); end
    n_cmp++; if (ex_rd !== 5'd6) begin n_bad++; $display("FAIL release_rd got %0d want 6", ex_rd); end
    id_valid = 0;
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL release_next_valid got %0b want 0", ex_valid); end
  endtask

  task automatic test_flush_hold();
    set_id(1, 32'h40, 0, 0, 0, 0, 0, 7, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    tick();
    mem_valid = 1; mem_reg_write = 1; mem_is_load = 0; mem_rd = 0; mem_result = 32'h123;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 0; wb_result = 32'h456;
    #1;
    n_cmp++; if (alu_src1 !== 32'h0) begin n_bad++; $display("FAIL x0_src1 got %h want 0", alu_src1); end
    flush = 1; ex_hold = 1;
    #1;
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL flush_id_ready got %0b want 0", id_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL flush_reg_write got %0b want 0", ex_reg_write); end
    n_cmp++; if (ex_rd !== 5'd7) begin n_bad++; $display("FAIL flush_rd_kept got %0d want 7", ex_rd); end
    flush = 0; ex_hold = 0;
    idle_mem_wb();
  endtask

  task automatic test_link();
    set_id(1, 32'h100, 0, 0, 0, 0, 32'h8, 1, 4'b0000, 2'b01, 2'b10, 1, 0, 0);
    tick();
    n_cmp++; if (alu_src1 !== 32'h100) begin n_bad++; $display("FAIL link_src1 got %h want 100", alu_src1); end
    n_cmp++; if (alu_src2 !== 32'd4) begin n_bad++; $display("FAIL link_src2 got %h want 4", alu_src2); end
    n_cmp++; if (ex_pc !== 32'h100) begin n_bad++; $display("FAIL link_pc got %h want 100", ex_pc); end
    set_id(1, 32'h104, 0, 0, 0, 0, 32'h8, 1, 4'b0000, 2'b11, 2'b11, 1, 0, 0);
    tick();
    n_cmp++; if (alu_src1 !== 32'h0) begin n_bad++; $display("FAIL sel11_src1 got %h want 0", alu_src1); end
    n_cmp++; if (alu_src2 !== 32'h0) begin n_bad++; $display("FAIL sel11_src2 got %h want 0", alu_src2); end
  endtask

  task automatic test_reset_mid();
    set_id(1, 32'h200, 0, 0, 0, 0, 0, 2, 4'b0110, 2'b01, 2'b01, 1, 0, 1);
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %0b want 1", ex_valid); end
    n_cmp++; if (ex_is_store !== 1'b1) begin n_bad++; $display("FAIL pre_reset_store got %0b want 1", ex_is_store); end
    #2;
    reset = 1;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got %0b want 0", ex_valid); end
    n_cmp++; if (alu_src1 !== 32'h0) begin n_bad++; $display("FAIL async_reset_src1 got %h want 0", alu_src1); end
    n_cmp++; if (alu_opcode !== 4'h0) begin n_bad++; $display("FAIL async_reset_opcode got %h want 0", alu_opcode); end
    id_valid = 0;
    tick();
    reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_hold_refresh();
    test_flush_hold();
    test_link();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register for the Eka core. It sits directly upstream of the ALU and drives its src1, src2 and opcode inputs. It latches decoded instructions and forwards results from the MEM and WB stages. It also detects load-use hazards, inserting a single bubble, and handles flush and hold.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_ready  out  1  stage accepts id_* this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  regfile read port 1
id_rs2_data  in  XLEN  regfile read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RA_W  source register 1 address
id_rs2  in  RA_W  source register 2 address
id_rd  in  RA_W  destination register address
id_alu_op  in  4  ALU opcode encoding (0000 add … 1101 sra)
id_src1_sel  in  2  00 rs1, 01 pc, 10 zero
id_src2_sel  in  2  00 rs2, 01 imm, 10 constant 4
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_store  in  1  instruction is a store
ex_hold  in  1  downstream stall; freeze EX contents
flush  in  1  squash EX and reject ID (taken branch or jump)
mem_valid  in  1  MEM stage instruction valid
mem_reg_write  in  1  MEM instruction writes rd
mem_is_load  in  1  MEM instruction is a load
mem_rd  in  RA_W  MEM destination register
mem_result  in  XLEN  MEM ALU result
wb_valid  in  1  WB stage instruction valid
wb_reg_write  in  1  WB instruction writes rd
wb_rd  in  RA_W  WB destination register
wb_result  in  XLEN  WB final write data
alu_src1  out  XLEN  ALU operand 1
alu_src2  out  XLEN  ALU operand 2
alu_opcode  out  4  ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_valid  out  1  EX instruction valid
ex_pc  out  XLEN  EX instruction PC
ex_imm  out  XLEN  EX immediate
ex_rd  out  RA_W  EX destination register
ex_reg_write  out  1  EX writes rd (gated by ex_valid)
ex_is_load  out  1  EX load (gated by ex_valid)
ex_is_store  out  1  EX store (gated by ex_valid)

Behaviour:
- Reset, asynchronous, active-high: every register clears to 0. ex_valid=0, alu_opcode=0000, all data outputs 0.
- Forward function fwd(addr, regval), applied in priority order:
  - If mem_valid & mem_reg_write & ~mem_is_load & mem_rd==addr & addr!=0, use mem_result.
  - Else if wb_valid & wb_reg_write & wb_rd==addr & addr!=0, use wb_result.
  - Else use regval.
  - Address x0 always yields regval.
- Capture path: the ID operands pass through fwd using the WB term only. MEM values are forwarded later from EX.
- EX operands are combinational from the registered state:
  - r1 = fwd(ex_rs1, ex_rs1_data), r2 = fwd(ex_rs2, ex_rs2_data).
  - alu_src1 = r1, ex_pc, or 0, per src1_sel.
  - alu_src2 = r2, ex_imm, or 32'd4, per src2_sel.
  - ex_store_data = r2.
  - Select encoding 11 drives 0.
- Load-use hazard, combinational: lu = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
- id_ready = ~ex_hold & ~lu & ~flush.
- Next-state priority, evaluated at each edge:
  1. flush: ex_valid←0; all other fields unchanged. flush overrides ex_hold.
  2. ex_hold: all fields held, except ex_rs1_data←r1 and ex_rs2_data←r2. This refresh keeps a WB producer that retires during the hold from being lost.
  3. lu: ex_valid←0 (bubble) and ID is not accepted. Next cycle the load is in WB and is forwarded from there.
  4. Otherwise: capture id_* and set ex_valid←id_valid.
- Latency: one cycle from ID acceptance to ALU operands.
- Load-use costs exactly one bubble cycle.
- Assertion: ex_valid & mem_valid & mem_is_load & mem_rd matching ex_rs1 or ex_rs2 (non-zero) never occurs.
- Flush during an lu cycle: flush wins and the lu bubble is irrelevant.

Decomposition:
- Shared package core_pkg holds:
  - ALU opcode localparams (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLT=4'b0010, …).
  - SRC1_* and SRC2_* select encodings.
  - XLEN and RA_W.
- One sub-module, fwd_mux: a combinational priority forwarder. Instantiate it four times: ID rs1 and rs2 with the WB term only, EX rs1 and rs2 with MEM and WB.

Test Plan:
1. Reset mid-stream: assert reset while ex_valid=1 → ex_valid=0 and alu_src1=0 immediately, without waiting for clk.
2. Back-to-back ALU forward: addi x1,x0,5 then add x2,x1,x1. The second instruction in EX sees mem_rd=1, mem_result=5 → alu_src1=alu_src2=5, alu_opcode=0000.
3. Load-use: lw x3 in EX, id_rs1=3, id_valid=1 → id_ready=0. Next cycle ex_valid=0. The following cycle wb_result=0xDEADBEEF → alu_src1=0xDEADBEEF.
4. Hold refresh: ex_hold=1 for 2 cycles while the x5 producer retires via WB (wb_result=0x77). After release, alu_src2=0x77 and src2_sel=00.
5. Flush plus hold in the same cycle: next ex_valid=0, id_ready=0. With x0 as destination of MEM (mem_rd=0, mem_result=0x123), an EX read of x0 → alu_src1=0.
6. jal-style link: src1_sel=01, src2_sel=10, ex_pc=0x100 → alu_src1=0x100, alu_src2=4.
